// File: rtl/lfsr_pkg.sv
// Shared definitions for the PRBS datapath: controller FSM encoding, LFSR width,
// feedback taps and the zero-detect rule that keeps the all-zero state escapable.
package lfsr_pkg;

  localparam int NB_LFSR = 8;
  localparam logic [NB_LFSR-1:0] TAP_MASK = 8'h8C;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_ACQUIRE = 3'd2,
    ST_RUN     = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Zero-detect term forces a 1 into the feedback so the register leaves 0x00.
  function automatic logic [NB_LFSR-1:0] lfsr_next(input logic [NB_LFSR-1:0] x);
    logic fb;
    fb = (^(x & TAP_MASK)) ^ (x[NB_LFSR-2:0] == '0);
    return {x[NB_LFSR-2:0], fb};
  endfunction

endpackage

// File: rtl/lfsr_ber_controller_if.sv
// Host/checker-facing signal bundle of the BER test sequencer.
interface lfsr_ber_controller_if #(
  parameter int NB_LFSR  = lfsr_pkg::NB_LFSR,
  parameter int NB_COUNT = 16
);
  logic                i_start;
  logic [NB_LFSR-1:0]  i_seed;
  logic [NB_COUNT-1:0] i_num_words;
  logic [7:0]          i_err_period;
  logic                i_lock;
  logic                o_soft_reset;
  logic [NB_LFSR-1:0]  o_seed;
  logic                o_valid;
  logic                o_err_inject;
  logic                o_busy;
  logic                o_done;
  logic                o_pass;
  logic                o_timeout;
  logic [7:0]          o_lock_loss_count;
  logic [NB_COUNT-1:0] o_word_count;

  modport master (
    output i_start, i_seed, i_num_words, i_err_period, i_lock,
    input  o_soft_reset, o_seed, o_valid, o_err_inject, o_busy, o_done,
           o_pass, o_timeout, o_lock_loss_count, o_word_count
  );

  modport slave (
    input  i_start, i_seed, i_num_words, i_err_period, i_lock,
    output o_soft_reset, o_seed, o_valid, o_err_inject, o_busy, o_done,
           o_pass, o_timeout, o_lock_loss_count, o_word_count
  );
endinterface

// File: rtl/sat_counter.sv
// Unsigned up-counter with synchronous clear that holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != {W{1'b1}}))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/lfsr_ber_controller.sv
// BER test sequencer: seeds the PRBS generator, waits for checker lock, streams a
// programmed number of words with optional periodic corruption and reports the result.
module lfsr_ber_controller #(
  parameter int NB_LFSR      = lfsr_pkg::NB_LFSR,
  parameter int NB_COUNT     = 16,
  parameter int LOCK_TIMEOUT = 64
) (
  input logic                  clk,
  input logic                  reset,
  lfsr_ber_controller_if.slave bus
);
  import lfsr_pkg::*;

  localparam int                NB_ACQ   = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [NB_ACQ-1:0] ACQ_LAST = NB_ACQ'(LOCK_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [NB_LFSR-1:0]  seed_q;
  logic [NB_COUNT-1:0] num_words_q, word_cnt_q;
  logic [7:0]          period_q, pos_q, pos_d;
  logic                lock_q, timeout_q, pass_q;
  logic                soft_reset_q, valid_q, err_inject_q, busy_q, done_q;
  logic                soft_reset_d, valid_d, err_inject_d, busy_d, done_d;
  logic [NB_ACQ-1:0]   acq_cnt;
  logic [7:0]          loss_cnt;
  logic                load_en, loss_inc, timeout_hit;

  // Configuration is captured on entry to LOAD so o_seed is already valid while
  // o_soft_reset is high and the generator can load it in that same cycle.
  assign load_en  = (state_d == ST_LOAD);
  assign loss_inc = (state_q == ST_RUN) && lock_q && !bus.i_lock;

  sat_counter #(.W(8)) u_loss_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (load_en),
    .en_i  (loss_inc),
    .cnt_o (loss_cnt)
  );

  sat_counter #(.W(NB_ACQ)) u_acq_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (load_en),
    .en_i  (state_q == ST_ACQUIRE),
    .cnt_o (acq_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    unique case (state_q)
      ST_IDLE:    if (bus.i_start) state_d = ST_LOAD;
      ST_LOAD:    state_d = ST_ACQUIRE;
      ST_ACQUIRE: begin
        if (bus.i_lock) begin
          state_d = (num_words_q == '0) ? ST_DONE : ST_RUN;
        end else if (acq_cnt == ACQ_LAST) begin
          state_d     = ST_DONE;
          timeout_hit = 1'b1;
        end
      end
      ST_RUN:     if (word_cnt_q + NB_COUNT'(1) == num_words_q) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so every strobe lines
  // up with the state it belongs to without any input-to-output path.
  always_comb begin
    soft_reset_d = (state_d == ST_LOAD);
    valid_d      = (state_d == ST_ACQUIRE) || (state_d == ST_RUN);
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);
    pos_d        = pos_q;
    if ((state_d == ST_RUN) && (period_q != 8'd0))
      pos_d = ((state_q != ST_RUN) || (pos_q == period_q)) ? 8'd1 : pos_q + 8'd1;
    err_inject_d = (state_d == ST_RUN) && (period_q != 8'd0) && (pos_d == period_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seed_q       <= '0;
      num_words_q  <= '0;
      period_q     <= '0;
      word_cnt_q   <= '0;
      pos_q        <= '0;
      lock_q       <= 1'b0;
      timeout_q    <= 1'b0;
      pass_q       <= 1'b0;
      soft_reset_q <= 1'b0;
      valid_q      <= 1'b0;
      err_inject_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      soft_reset_q <= soft_reset_d;
      valid_q      <= valid_d;
      err_inject_q <= err_inject_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pos_q        <= pos_d;
      lock_q       <= (state_q == ST_RUN) ? bus.i_lock : 1'b1;
      if (state_q == ST_RUN) word_cnt_q <= word_cnt_q + NB_COUNT'(1);
      if (timeout_hit) timeout_q <= 1'b1;
      // Includes a loss detected on the very edge that leaves RUN.
      if (done_d) pass_q <= !(timeout_q || timeout_hit) && (loss_cnt == 8'd0) && !loss_inc;
      if (load_en) begin
        seed_q      <= bus.i_seed;
        num_words_q <= bus.i_num_words;
        period_q    <= bus.i_err_period;
        word_cnt_q  <= '0;
        pos_q       <= '0;
        timeout_q   <= 1'b0;
        pass_q      <= 1'b0;
      end
    end
  end

  assign bus.o_soft_reset      = soft_reset_q;
  assign bus.o_seed            = seed_q;
  assign bus.o_valid           = valid_q;
  assign bus.o_err_inject      = err_inject_q;
  assign bus.o_busy            = busy_q;
  assign bus.o_done            = done_q;
  assign bus.o_pass            = pass_q;
  assign bus.o_timeout         = timeout_q;
  assign bus.o_lock_loss_count = loss_cnt;
  assign bus.o_word_count      = word_cnt_q;
endmodule

// File: tb/tb_lfsr_ber_controller.sv
// Directed bench for lfsr_ber_controller: one task per scenario, hand-computed expectations.
module tb_lfsr_ber_controller;
  import lfsr_pkg::*;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  lfsr_ber_controller_if #(.NB_LFSR(8), .NB_COUNT(16)) bus ();

  lfsr_ber_controller #(.NB_LFSR(8), .NB_COUNT(16), .LOCK_TIMEOUT(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulses i_start for one edge; returns in the LOAD cycle.
  task automatic start_test(input logic [7:0] seed, input logic [15:0] nw, input logic [7:0] per);
    bus.i_seed       = seed;
    bus.i_num_words  = nw;
    bus.i_err_period = per;
    bus.i_start      = 1'b1;
    step();
    bus.i_start      = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    tests_run++; if (bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0 || bus.o_done !== 1'b0) begin tests_failed++; $display("FAIL reset_strobes: busy=%b valid=%b done=%b expected 0 0 0", bus.o_busy, bus.o_valid, bus.o_done); end
    tests_run++; if (bus.o_seed !== 8'h00 || bus.o_word_count !== 16'd0 || bus.o_lock_loss_count !== 8'd0) begin tests_failed++; $display("FAIL reset_values: seed=%h wc=%0d loss=%0d expected 0 0 0", bus.o_seed, bus.o_word_count, bus.o_lock_loss_count); end
    tests_run++; if (bus.o_pass !== 1'b0 || bus.o_timeout !== 1'b0 || bus.o_soft_reset !== 1'b0 || bus.o_err_inject !== 1'b0) begin tests_failed++; $display("FAIL reset_flags: pass=%b to=%b sr=%b inj=%b expected 0", bus.o_pass, bus.o_timeout, bus.o_soft_reset, bus.o_err_inject); end
    reset = 1'b0;
    step();
    tests_run++; if (bus.o_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_idle: busy=%b expected 0", bus.o_busy); end
  endtask

  task automatic test_clean_run();
    int vcnt;
    int inj;
    vcnt = 0;
    inj  = 0;
    bus.i_lock = 1'b0;
    start_test(8'h01, 16'd26, 8'd0);
    tests_run++; if (bus.o_soft_reset !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_busy !== 1'b1) begin tests_failed++; $display("FAIL clean_load: sr=%b valid=%b busy=%b expected 1 0 1", bus.o_soft_reset, bus.o_valid, bus.o_busy); end
    tests_run++; if (bus.o_seed !== 8'h01) begin tests_failed++; $display("FAIL clean_seed: got %h expected 01", bus.o_seed); end
    step();
    tests_run++; if (bus.o_valid !== 1'b1 || bus.o_soft_reset !== 1'b0) begin tests_failed++; $display("FAIL clean_acq_valid: valid=%b sr=%b expected 1 0", bus.o_valid, bus.o_soft_reset); end
    repeat (7) step();
    bus.i_lock = 1'b1;
    step();
    for (int w = 1; w <= 26; w++) begin
      if (bus.o_valid === 1'b1) vcnt++;
      if (bus.o_err_inject === 1'b1) inj++;
      step();
    end
    tests_run++; if (vcnt !== 26) begin tests_failed++; $display("FAIL clean_valid_count: got %0d expected 26", vcnt); end
    tests_run++; if (inj !== 0) begin tests_failed++; $display("FAIL clean_no_inject: got %0d expected 0", inj); end
    tests_run++; if (bus.o_done !== 1'b1 || bus.o_valid !== 1'b0) begin tests_failed++; $display("FAIL clean_done: done=%b valid=%b expected 1 0", bus.o_done, bus.o_valid); end
    tests_run++; if (bus.o_word_count !== 16'd26 || bus.o_lock_loss_count !== 8'd0) begin tests_failed++; $display("FAIL clean_counts: wc=%0d loss=%0d expected 26 0", bus.o_word_count, bus.o_lock_loss_count); end
    tests_run++; if (bus.o_pass !== 1'b1 || bus.o_timeout !== 1'b0) begin tests_failed++; $display("FAIL clean_pass: pass=%b to=%b expected 1 0", bus.o_pass, bus.o_timeout); end
    step();
    tests_run++; if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_pass !== 1'b1) begin tests_failed++; $display("FAIL clean_after: done=%b busy=%b pass=%b expected 0 0 1", bus.o_done, bus.o_busy, bus.o_pass); end
  endtask

  task automatic test_err_inject();
    logic [9:0] inj_mask;
    inj_mask = '0;
    bus.i_lock = 1'b0;
    start_test(8'hA5, 16'd10, 8'd3);
    step();
    tests_run++; if (bus.o_err_inject !== 1'b0) begin tests_failed++; $display("FAIL inj_acquire: got %b expected 0", bus.o_err_inject); end
    bus.i_lock = 1'b1;
    step();
    for (int w = 1; w <= 10; w++) begin
      bus.i_lock = !((w == 4) || (w == 7) || (w == 10));
      inj_mask[w-1] = bus.o_err_inject;
      step();
    end
    bus.i_lock = 1'b1;
    tests_run++; if (inj_mask !== 10'h124) begin tests_failed++; $display("FAIL inj_words: got %h expected 124", inj_mask); end
    tests_run++; if (bus.o_done !== 1'b1 || bus.o_lock_loss_count !== 8'd3) begin tests_failed++; $display("FAIL inj_loss: done=%b loss=%0d expected 1 3", bus.o_done, bus.o_lock_loss_count); end
    tests_run++; if (bus.o_pass !== 1'b0 || bus.o_word_count !== 16'd10) begin tests_failed++; $display("FAIL inj_result: pass=%b wc=%0d expected 0 10", bus.o_pass, bus.o_word_count); end
    step();
  endtask

  task automatic test_timeout();
    int vcnt;
    vcnt = 0;
    bus.i_lock = 1'b0;
    start_test(8'h3C, 16'd5, 8'd0);
    step();
    for (int a = 1; a <= 64; a++) begin
      if (bus.o_valid === 1'b1) vcnt++;
      step();
    end
    tests_run++; if (vcnt !== 64) begin tests_failed++; $display("FAIL to_acq_cycles: got %0d expected 64", vcnt); end
    tests_run++; if (bus.o_done !== 1'b1 || bus.o_timeout !== 1'b1 || bus.o_valid !== 1'b0) begin tests_failed++; $display("FAIL to_done: done=%b to=%b valid=%b expected 1 1 0", bus.o_done, bus.o_timeout, bus.o_valid); end
    tests_run++; if (bus.o_pass !== 1'b0 || bus.o_word_count !== 16'd0) begin tests_failed++; $display("FAIL to_result: pass=%b wc=%0d expected 0 0", bus.o_pass, bus.o_word_count); end
    step();
  endtask

  task automatic test_zero_len();
    bus.i_lock = 1'b1;
    start_test(8'h77, 16'd0, 8'd2);
    step();
    tests_run++; if (bus.o_valid !== 1'b1) begin tests_failed++; $display("FAIL zero_acq: valid=%b expected 1", bus.o_valid); end
    step();
    tests_run++; if (bus.o_done !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_err_inject !== 1'b0) begin tests_failed++; $display("FAIL zero_done: done=%b valid=%b inj=%b expected 1 0 0", bus.o_done, bus.o_valid, bus.o_err_inject); end
    tests_run++; if (bus.o_pass !== 1'b1 || bus.o_word_count !== 16'd0 || bus.o_timeout !== 1'b0) begin tests_failed++; $display("FAIL zero_result: pass=%b wc=%0d to=%b expected 1 0 0", bus.o_pass, bus.o_word_count, bus.o_timeout); end
    step();
  endtask

  task automatic test_back_to_back();
    bus.i_lock       = 1'b1;
    bus.i_seed       = 8'h33;
    bus.i_num_words  = 16'd2;
    bus.i_err_period = 8'd0;
    bus.i_start      = 1'b1;
    step();
    step();
    step();
    step();
    step();
    tests_run++; if (bus.o_done !== 1'b1 || bus.o_pass !== 1'b1) begin tests_failed++; $display("FAIL b2b_first_done: done=%b pass=%b expected 1 1", bus.o_done, bus.o_pass); end
    step();
    tests_run++; if (bus.o_busy !== 1'b0 || bus.o_soft_reset !== 1'b0 || bus.o_pass !== 1'b1) begin tests_failed++; $display("FAIL b2b_idle: busy=%b sr=%b pass=%b expected 0 0 1", bus.o_busy, bus.o_soft_reset, bus.o_pass); end
    step();
    tests_run++; if (bus.o_soft_reset !== 1'b1 || bus.o_busy !== 1'b1 || bus.o_pass !== 1'b0) begin tests_failed++; $display("FAIL b2b_reload: sr=%b busy=%b pass=%b expected 1 1 0", bus.o_soft_reset, bus.o_busy, bus.o_pass); end
    bus.i_start = 1'b0;
    repeat (4) step();
    tests_run++; if (bus.o_done !== 1'b1 || bus.o_word_count !== 16'd2) begin tests_failed++; $display("FAIL b2b_second_done: done=%b wc=%0d expected 1 2", bus.o_done, bus.o_word_count); end
    step();
  endtask

  task automatic test_saturation();
    int inj;
    logic [7:0] loss_mid;
    inj = 0;
    loss_mid = '0;
    bus.i_lock = 1'b0;
    start_test(8'h5E, 16'd600, 8'd0);
    step();
    bus.i_lock = 1'b1;
    step();
    for (int w = 1; w <= 600; w++) begin
      bus.i_lock = w[0] ? 1'b0 : 1'b1;
      if (w == 509) loss_mid = bus.o_lock_loss_count;
      if (bus.o_err_inject === 1'b1) inj++;
      if (w == 510) begin
        tests_run++; if (bus.o_lock_loss_count !== 8'd255) begin tests_failed++; $display("FAIL sat_reach: got %0d expected 255", bus.o_lock_loss_count); end
      end
      step();
    end
    bus.i_lock = 1'b1;
    tests_run++; if (loss_mid !== 8'd254) begin tests_failed++; $display("FAIL sat_before: got %0d expected 254", loss_mid); end
    tests_run++; if (bus.o_done !== 1'b1 || bus.o_lock_loss_count !== 8'd255) begin tests_failed++; $display("FAIL sat_final: done=%b loss=%0d expected 1 255", bus.o_done, bus.o_lock_loss_count); end
    tests_run++; if (bus.o_pass !== 1'b0 || bus.o_word_count !== 16'd600 || inj !== 0) begin tests_failed++; $display("FAIL sat_result: pass=%b wc=%0d inj=%0d expected 0 600 0", bus.o_pass, bus.o_word_count, inj); end
    step();
  endtask

  task automatic test_reset_mid_run();
    int dones;
    dones = 0;
    bus.i_lock = 1'b1;
    start_test(8'hC3, 16'd20, 8'd2);
    step();
    step();
    repeat (4) step();
    tests_run++; if (bus.o_word_count !== 16'd4 || bus.o_valid !== 1'b1) begin tests_failed++; $display("FAIL rst_word5: wc=%0d valid=%b expected 4 1", bus.o_word_count, bus.o_valid); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests_run++; if (bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0 || bus.o_err_inject !== 1'b0 || bus.o_done !== 1'b0 || bus.o_soft_reset !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_strobes: busy=%b valid=%b inj=%b done=%b sr=%b expected 0", bus.o_busy, bus.o_valid, bus.o_err_inject, bus.o_done, bus.o_soft_reset); end
    tests_run++; if (bus.o_seed !== 8'h00 || bus.o_word_count !== 16'd0 || bus.o_lock_loss_count !== 8'd0 || bus.o_pass !== 1'b0 || bus.o_timeout !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_values: seed=%h wc=%0d loss=%0d pass=%b to=%b expected 0", bus.o_seed, bus.o_word_count, bus.o_lock_loss_count, bus.o_pass, bus.o_timeout); end
    for (int c = 0; c < 20; c++) begin
      if (bus.o_done === 1'b1) dones++;
      step();
    end
    tests_run++; if (dones !== 0) begin tests_failed++; $display("FAIL rst_no_done: got %0d pulses expected 0", dones); end
    start_test(8'h5A, 16'd6, 8'd0);
    step();
    step();
    step();
    bus.i_start = 1'b1;
    bus.i_seed  = 8'hFF;
    step();
    bus.i_start = 1'b0;
    repeat (4) step();
    tests_run++; if (bus.o_done !== 1'b1 || bus.o_word_count !== 16'd6 || bus.o_seed !== 8'h5A) begin tests_failed++; $display("FAIL rst_restart: done=%b wc=%0d seed=%h expected 1 6 5a", bus.o_done, bus.o_word_count, bus.o_seed); end
    step();
    step();
    tests_run++; if (bus.o_busy !== 1'b0 || bus.o_soft_reset !== 1'b0) begin tests_failed++; $display("FAIL rst_ignored_start: busy=%b sr=%b expected 0 0", bus.o_busy, bus.o_soft_reset); end
  endtask

  initial begin
    tests_run        = 0;
    tests_failed     = 0;
    reset            = 1'b1;
    bus.i_start      = 1'b0;
    bus.i_seed       = '0;
    bus.i_num_words  = '0;
    bus.i_err_period = '0;
    bus.i_lock       = 1'b0;
    test_reset();
    test_clean_run();
    test_err_inject();
    test_timeout();
    test_zero_len();
    test_back_to_back();
    test_saturation();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
